// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and a constant-foldable ceiling-log2 helper used to size the step counter.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Ripple-carry adder built from a chain of full_adder cells; the multiplier
// uses it for each partial-product accumulation step.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  // Cells are kept as discrete instances so the carry chain survives synthesis.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    (* dont_touch = "true" *)
    full_adder u_fa (
      .x    (x[i]),
      .y    (y[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier with valid/ready handshakes;
// one partial-product add-and-shift per clock, fixed WIDTH-cycle latency.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int CW = clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]      count_q, count_d;

  logic [WIDTH-1:0]   addSum;
  logic               addCout;
  logic [2*WIDTH-1:0] pStep;

  ripple_carry_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .x    (p_q[2*WIDTH-1:WIDTH]),
    .y    (mcand_q),
    .cin  (1'b0),
    .sum  (addSum),
    .cout (addCout)
  );

  // The adder carry lands in the top bit of the shifted product so it is never lost.
  always_comb begin
    if (p_q[0]) begin
      pStep = {addCout, addSum, p_q[WIDTH-1:1]};
    end else begin
      pStep = {1'b0, p_q[2*WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    p_d       = p_q;
    count_d   = count_q;
    result_d  = result_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mcand_d = a;
          p_d     = {{WIDTH{1'b0}}, b};
          count_d = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy    = 1'b1;
        p_d     = pStep;
        count_d = count_q + 1'b1;
        if (count_q == LAST_STEP) begin
          result_d = pStep;
          state_d  = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      p_q      <= '0;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      p_q      <= p_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: a cycle-level behavioural
// model checked every cycle, plus directed and randomized operations.
module tb_shift_add_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inValid = 1'b0;
  logic          outReady = 1'b0;
  logic [W-1:0]  opA = '0;
  logic [W-1:0]  opB = '0;
  logic          inReady;
  logic          outValid;
  logic          busy;
  logic [PW-1:0] result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .a         (opA),
    .b         (opB),
    .out_valid (outValid),
    .out_ready (outReady),
    .result    (result),
    .busy      (busy)
  );

  // Reference: 0 = waiting for operands, 1 = computing, 2 = holding the product.
  int            mPhase = 0;
  int            mLeft = 0;
  logic [PW-1:0] mProd = '0;
  logic [PW-1:0] mResult = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase  <= 0;
      mLeft   <= 0;
      mProd   <= '0;
      mResult <= '0;
    end else begin
      case (mPhase)
        0: if (inValid) begin
          mProd  <= PW'(opA) * PW'(opB);
          mLeft  <= W;
          mPhase <= 1;
        end
        1: begin
          if (mLeft == 1) begin
            mPhase  <= 2;
            mResult <= mProd;
          end
          mLeft <= mLeft - 1;
        end
        2: if (outReady) mPhase <= 0;
        default: mPhase <= 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cycleInReady", 32'(inReady), 32'(mPhase == 0));
    checkOutput("cycleBusy", 32'(busy), 32'(mPhase == 1));
    checkOutput("cycleOutValid", 32'(outValid), 32'(mPhase == 2));
    checkOutput("cycleResult", 32'(result), 32'(mResult));
  end

  // Called at #1 after an edge with the block idle; leaves it idle at #1 after the handshake edge.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input int stall,
                               input bit noise, input logic [PW-1:0] lit, input string tag);
    int lat;
    opA      = x;
    opB      = y;
    inValid  = 1'b1;
    outReady = (stall == 0);
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput({tag, " busyAfterAccept"}, 32'(busy), 32'd1);
    checkOutput({tag, " inReadyAfterAccept"}, 32'(inReady), 32'd0);
    lat = 0;
    while (!outValid && lat < 4 * W) begin
      if (noise) begin
        inValid = 1'($urandom_range(0, 1));
        opA     = W'($urandom);
        opB     = W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    inValid = 1'b0;
    checkOutput({tag, " latency"}, 32'(lat), 32'(W));
    checkOutput({tag, " result"}, 32'(result), 32'(lit));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkOutput({tag, " holdValid"}, 32'(outValid), 32'd1);
      checkOutput({tag, " holdResult"}, 32'(result), 32'(lit));
      checkOutput({tag, " holdInReady"}, 32'(inReady), 32'd0);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, " pulseEnd"}, 32'(outValid), 32'd0);
    checkOutput({tag, " idleAgain"}, 32'(inReady), 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetInReady", 32'(inReady), 32'd1);
    checkOutput("resetOutValid", 32'(outValid), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetResult", 32'(result), 32'd0);
    rst_n    = 1'b1;
    outReady = 1'b1;

    applyStimulus(8'd13, 8'd11, 0, 1'b0, 16'h008F, "basic");
    applyStimulus(8'd255, 8'd255, 0, 1'b0, 16'hFE01, "max");
    applyStimulus(8'd0, 8'd200, 0, 1'b0, 16'h0000, "zeroA");
    applyStimulus(8'd200, 8'd0, 0, 1'b0, 16'h0000, "zeroB");
    applyStimulus(8'd1, 8'd255, 0, 1'b0, 16'h00FF, "oneA");
    applyStimulus(8'd100, 8'd3, 5, 1'b0, 16'h012C, "backpressure");
    applyStimulus(8'd7, 8'd9, 0, 1'b1, 16'd63, "isolateFirst");
    applyStimulus(8'd15, 8'd15, 0, 1'b1, 16'd225, "isolateSecond");

    opA     = 8'd77;
    opB     = 8'd77;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetInReady", 32'(inReady), 32'd1);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    checkOutput("midResetOutValid", 32'(outValid), 32'd0);
    checkOutput("midResetResult", 32'(result), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'd2, 8'd3, 0, 1'b0, 16'd6, "afterReset");

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 50 == 0) ra = '1;
      if (n % 70 == 0) rb = '0;
      applyStimulus(ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    PW'(ra) * PW'(rb), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
